// File: rtl/echo_delay_ctrl_if.sv
// rtl/echo_delay_ctrl_if.sv - sample streams, effect gains and delay-line memory port of echo_delay_ctrl
interface echo_delay_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 512
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] pi_data;
    logic                  pi_valid;
    logic                  po_ready;
    logic [AW-1:0]         pi_delay;
    logic [DATA_WIDTH-1:0] pi_feedback;
    logic [DATA_WIDTH-1:0] pi_mix;
    logic [DATA_WIDTH-1:0] po_data;
    logic                  po_valid;
    logic                  pi_ready;
    logic [AW-1:0]         po_mem_addr;
    logic [DATA_WIDTH-1:0] po_mem_data;
    logic                  po_mem_w_en;
    logic                  po_mem_r_en;
    logic [DATA_WIDTH-1:0] pi_mem_data;

    modport master (
        input  pi_data, pi_valid, pi_delay, pi_feedback, pi_mix, pi_ready, pi_mem_data,
        output po_ready, po_data, po_valid, po_mem_addr, po_mem_data, po_mem_w_en, po_mem_r_en
    );

    modport slave (
        output pi_data, pi_valid, pi_delay, pi_feedback, pi_mix, pi_ready, pi_mem_data,
        input  po_ready, po_data, po_valid, po_mem_addr, po_mem_data, po_mem_w_en, po_mem_r_en
    );
endinterface

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - echo/delay controller: zero-fills the delay line, then read/calc/write/out per sample
module echo_delay_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 512,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic              pi_clk,
    input  logic              pi_sreset,
    echo_delay_ctrl_if.master bus,
    output logic              po_clear_busy
);
    typedef enum logic [2:0] {
        ST_CLEAR, ST_IDLE, ST_READ, ST_CALC, ST_WRITE, ST_OUT
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic signed [2*DATA_WIDTH-1:0] WIDE_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [2*DATA_WIDTH-1:0] WIDE_MIN = ~WIDE_MAX;

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         d_q, d_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] fb_q, fb_d;
    logic [DATA_WIDTH-1:0] mix_q, mix_d;
    logic [DATA_WIDTH-1:0] wet_q, wet_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    // x + Q1.(W-1) gain applied to m, saturated; the wide sum can never overflow.
    function automatic logic [DATA_WIDTH-1:0] gain_add(
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] m,
        input logic [DATA_WIDTH-1:0] g
    );
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [2*DATA_WIDTH-1:0] sum;
        prod = $signed({{DATA_WIDTH{m[DATA_WIDTH-1]}}, m}) *
               $signed({{DATA_WIDTH{g[DATA_WIDTH-1]}}, g});
        sum  = $signed({{DATA_WIDTH{x[DATA_WIDTH-1]}}, x}) + (prod >>> (DATA_WIDTH-1));
        if (sum > WIDE_MAX) begin
            return WIDE_MAX[DATA_WIDTH-1:0];
        end else if (sum < WIDE_MIN) begin
            return WIDE_MIN[DATA_WIDTH-1:0];
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge pi_clk) begin
        if (pi_sreset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            d_q       <= '0;
            x_q       <= '0;
            fb_q      <= '0;
            mix_q     <= '0;
            wet_q     <= '0;
            y_q       <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            d_q       <= d_d;
            x_q       <= x_d;
            fb_q      <= fb_d;
            mix_q     <= mix_d;
            wet_q     <= wet_d;
            y_q       <= y_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        d_d       = d_q;
        x_d       = x_q;
        fb_d      = fb_q;
        mix_d     = mix_q;
        wet_d     = wet_q;
        y_d       = y_q;
        out_d     = out_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.pi_valid) begin
                    x_d     = bus.pi_data;
                    d_d     = (bus.pi_delay == '0) ? AW'(1) : bus.pi_delay;
                    fb_d    = bus.pi_feedback;
                    mix_d   = bus.pi_mix;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                wet_d   = gain_add(x_q, bus.pi_mem_data, fb_q);
                y_d     = gain_add(x_q, bus.pi_mem_data, mix_q);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                out_d    = y_q;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (bus.pi_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Single memory port: only one of read/write is ever active per cycle.
    always_comb begin
        bus.po_mem_addr = '0;
        bus.po_mem_data = '0;
        bus.po_mem_w_en = 1'b0;
        bus.po_mem_r_en = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                bus.po_mem_w_en = 1'b1;
                bus.po_mem_addr = clr_cnt_q;
            end
            ST_READ: begin
                bus.po_mem_r_en = 1'b1;
                bus.po_mem_addr = wr_ptr_q - d_q;
            end
            ST_WRITE: begin
                bus.po_mem_w_en = 1'b1;
                bus.po_mem_addr = wr_ptr_q;
                bus.po_mem_data = wet_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.po_ready   = (state_q == ST_IDLE);
    assign bus.po_valid   = (state_q == ST_OUT);
    assign bus.po_data    = out_q;
    assign po_clear_busy  = (state_q == ST_CLEAR);
endmodule
